// File: rtl/lag_bcd_encoder_pkg.sv
// Shared types and constants for the lag BCD encoder.
//   - Default geometry: 17-bit binary inputs, 5 BCD digits per field, 4 fields.
//   - Field order inside the 80-bit word: current, min, max, avg (field 0 in the low bits).
//   - Sentinels: MAX_BCDCOUNT marks "no value" for current/min/avg. The max field uses 0.
package lag_bcd_encoder_pkg;

  localparam int LAG_BIN_W   = 17;
  localparam int LAG_DIGITS  = 5;
  localparam int LAG_FIELDS  = 4;
  localparam int BCD_FIELD_W = 4 * LAG_DIGITS;

  localparam logic [LAG_BIN_W-1:0]   BCD_CLAMP    = 17'd99999;
  // 0xFFFFF is not a legal BCD pattern, so textgen can tell it apart from any real value.
  localparam logic [BCD_FIELD_W-1:0] MAX_BCDCOUNT = 20'hFFFFF;
  localparam logic [BCD_FIELD_W-1:0] MAX_FIELD_EMPTY = '0;

  typedef enum logic [1:0] {
    LAG_CUR = 2'd0,
    LAG_MIN = 2'd1,
    LAG_MAX = 2'd2,
    LAG_AVG = 2'd3
  } lag_field_e;

  // Value published for a field that has no valid measurement.
  function automatic logic [BCD_FIELD_W-1:0] field_sentinel(input lag_field_e f);
    return (f == LAG_MAX) ? MAX_FIELD_EMPTY : MAX_BCDCOUNT;
  endfunction

endpackage

// File: rtl/lag_bcd_encoder_if.sv
// Request/result bundle between the lag measurement side and the encoder.
//   master: measurement side. It drives start, the four lag values, valid_mask and commit_enable.
//   slave : the encoder. It drives busy, done and the packed bcdcount word.
interface lag_bcd_encoder_if #(
  parameter int BIN_WIDTH = 17,
  parameter int DIGITS    = 5,
  parameter int FIELDS    = 4
);
  logic                       start;
  logic [BIN_WIDTH-1:0]       lag_current;
  logic [BIN_WIDTH-1:0]       lag_min;
  logic [BIN_WIDTH-1:0]       lag_max;
  logic [BIN_WIDTH-1:0]       lag_avg;
  logic [FIELDS-1:0]          valid_mask;
  logic                       commit_enable;
  logic                       busy;
  logic                       done;
  logic [FIELDS*4*DIGITS-1:0] bcdcount;

  modport master (
    output start, lag_current, lag_min, lag_max, lag_avg, valid_mask, commit_enable,
    input  busy, done, bcdcount
  );

  modport slave (
    input  start, lag_current, lag_min, lag_max, lag_avg, valid_mask, commit_enable,
    output busy, done, bcdcount
  );
endinterface

// File: rtl/lag_bcd_encoder_bin2bcd_seq.sv
// Sequential double-dabble engine for a single field.
//   clk_i, rst_i : clock and synchronous active-high reset
//   load_i       : load bin_i into the shift register and clear the BCD accumulator
//   step_i       : one add-3/shift iteration
//   bin_i        : binary value to convert. It must already be clamped to DIGITS digits.
//   bcd_nxt_o    : accumulator value after the current step. It is valid while step_i is high.
//   last_o       : high on the BIN_WIDTH-th step. bcd_nxt_o is then the final result.
module bin2bcd_seq #(
  parameter int BIN_WIDTH = 17,
  parameter int DIGITS    = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [BIN_WIDTH-1:0]  bin_i,
  output logic [4*DIGITS-1:0]   bcd_nxt_o,
  output logic                  last_o
);
  localparam int FW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH);

  logic [DIGITS-1:0][3:0] bcd_q, adj;
  logic [BIN_WIDTH-1:0]   bin_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [FW-1:0]          adj_flat;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign adj[g] = (bcd_q[g] >= 4'd5) ? bcd_q[g] + 4'd3 : bcd_q[g];
  end

  assign adj_flat = adj;
  // Clamped inputs never need a digit above DIGITS, so the bit shifted out of the top is always 0.
  assign bcd_nxt_o = (adj_flat << 1) | FW'(bin_q[BIN_WIDTH-1]);
  assign last_o    = step_i && (cnt_q == CNT_W'(BIN_WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      bcd_q <= '0;
      bin_q <= bin_i;
      cnt_q <= '0;
    end else if (step_i) begin
      bcd_q <= bcd_nxt_o;
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/lag_bcd_encoder.sv
// Converts the four binary lag statistics into the packed BCD word for the lag display line.
// One shared double-dabble engine processes the fields in sequence.
// The finished word is published atomically, on the first cycle that commit_enable allows it.
//   clock, reset : video pixel clock and synchronous active-high reset
//   bus (slave)  : start, lag_current/min/max/avg, valid_mask and commit_enable come in.
//                  busy, done and bcdcount[79:0] go out.
//                  bcdcount layout: [19:0] current, [39:20] min, [59:40] max, [79:60] avg.
// Each field takes 18 cycles (1 load and 17 shifts), so one conversion takes 72 cycles.
// A start that arrives while busy is parked in a shadow set. The newest one wins.
module lag_bcd_encoder
  import lag_bcd_encoder_pkg::*;
#(
  parameter int BIN_WIDTH = LAG_BIN_W,
  parameter int DIGITS    = LAG_DIGITS,
  parameter int FIELDS    = LAG_FIELDS
) (
  input  logic             clock,
  input  logic             reset,
  lag_bcd_encoder_if.slave bus
);
  localparam int FIELD_W = 4 * DIGITS;
  localparam int IDX_W   = $clog2(FIELDS);
  localparam logic [BIN_WIDTH-1:0] CLAMP = BIN_WIDTH'(10**DIGITS - 1);

  // Storing happens on the last SHIFT edge, so it needs no state of its own.
  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_LOAD        = 2'd1;
  localparam logic [1:0] S_SHIFT       = 2'd2;
  localparam logic [1:0] S_WAIT_COMMIT = 2'd3;

  logic [1:0]                           state_q, state_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic [FIELDS-1:0][BIN_WIDTH-1:0]     work_val_q, work_val_d, shd_val_q, shd_val_d;
  logic [FIELDS-1:0]                    work_msk_q, work_msk_d, shd_msk_q, shd_msk_d;
  logic                                 pend_q, pend_d;
  logic [FIELDS-1:0][FIELD_W-1:0]       res_q, res_d, bcd_q, bcd_d;
  logic                                 done_q, done_d;

  logic [FIELDS-1:0][BIN_WIDTH-1:0]     req_val;
  logic [BIN_WIDTH-1:0]                 cur_bin, eng_bin;
  logic                                 eng_load, eng_step, eng_last;
  logic [FIELD_W-1:0]                   eng_bcd_nxt;
  logic                                 commit, to_shadow;

  assign req_val = {bus.lag_avg, bus.lag_max, bus.lag_min, bus.lag_current};
  assign cur_bin = work_val_q[idx_q];
  assign eng_bin = (cur_bin > CLAMP) ? CLAMP : cur_bin;

  assign commit = (state_q == S_WAIT_COMMIT) && bus.commit_enable;
  // A start on a commit edge with no pending request is taken straight into the working set.
  // Parking it in the shadow set instead would strand it once the FSM drops to IDLE.
  assign to_shadow = bus.start && (state_q != S_IDLE) && !(commit && !pend_q);

  bin2bcd_seq #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) u_eng (
    .clk_i     (clock),
    .rst_i     (reset),
    .load_i    (eng_load),
    .step_i    (eng_step),
    .bin_i     (eng_bin),
    .bcd_nxt_o (eng_bcd_nxt),
    .last_o    (eng_last)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    work_val_d = work_val_q;
    work_msk_d = work_msk_q;
    shd_val_d  = shd_val_q;
    shd_msk_d  = shd_msk_q;
    pend_d     = pend_q;
    res_d      = res_q;
    bcd_d      = bcd_q;
    done_d     = 1'b0;
    eng_load   = 1'b0;
    eng_step   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          work_val_d = req_val;
          work_msk_d = bus.valid_mask;
          idx_d      = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        eng_load = 1'b1;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        eng_step = 1'b1;
        if (eng_last) begin
          // Invalid fields still run all 18 cycles, which keeps the latency fixed.
          res_d[idx_q] = work_msk_q[idx_q] ? eng_bcd_nxt
                                           : field_sentinel(lag_field_e'(idx_q));
          if (idx_q == IDX_W'(FIELDS - 1)) begin
            state_d = S_WAIT_COMMIT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_WAIT_COMMIT: begin
        if (commit) begin
          bcd_d  = res_q;
          done_d = 1'b1;
          idx_d  = '0;
          if (pend_q) begin
            work_val_d = shd_val_q;
            work_msk_d = shd_msk_q;
            pend_d     = 1'b0;
            state_d    = S_LOAD;
          end else if (bus.start) begin
            work_val_d = req_val;
            work_msk_d = bus.valid_mask;
            state_d    = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (to_shadow) begin
      shd_val_d = req_val;
      shd_msk_d = bus.valid_mask;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      work_val_q <= '0;
      work_msk_q <= '0;
      shd_val_q  <= '0;
      shd_msk_q  <= '0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int f = 0; f < FIELDS; f++) begin
        res_q[f] <= field_sentinel(lag_field_e'(f));
        bcd_q[f] <= field_sentinel(lag_field_e'(f));
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      work_val_q <= work_val_d;
      work_msk_q <= work_msk_d;
      shd_val_q  <= shd_val_d;
      shd_msk_q  <= shd_msk_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      res_q      <= res_d;
      bcd_q      <= bcd_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.bcdcount = bcd_q;
endmodule

// File: tb/tb_lag_bcd_encoder.sv
module tb_lag_bcd_encoder;
  localparam logic [79:0] RST_WORD = {20'hFFFFF, 20'h00000, 20'hFFFFF, 20'hFFFFF};

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  lag_bcd_encoder_if bus ();

  lag_bcd_encoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic [16:0] c, input logic [16:0] mn, input logic [16:0] mx,
                        input logic [16:0] av, input logic [3:0] m);
    bus.lag_current = c;
    bus.lag_min     = mn;
    bus.lag_max     = mx;
    bus.lag_avg     = av;
    bus.valid_mask  = m;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Returns the number of edges from the start edge to the done edge, or -1 on timeout.
  task automatic wait_done(input int bound, output int lat);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;
  int ndone;
  int done_at[2];
  logic [79:0] word_at[2];
  logic changed;

  initial begin
    bus.start = 1'b0;
    bus.commit_enable = 1'b1;
    set_in(17'd0, 17'd0, 17'd0, 17'd0, 4'h0);

    // Reset
    repeat (3) tick();
    chk("rst_bcd", bus.bcdcount, RST_WORD);
    chk("rst_busy", {79'd0, bus.busy}, 80'd0);
    chk("rst_done", {79'd0, bus.done}, 80'd0);
    reset = 1'b0;
    tick();

    // Basic conversion with all fields valid
    set_in(17'd123, 17'd45, 17'd99999, 17'd1000, 4'hF);
    pulse_start();
    chk("a_busy", {79'd0, bus.busy}, 80'd1);
    chk("a_hold", bus.bcdcount, RST_WORD);
    wait_done(200, lat);
    chk("a_lat", 80'(lat), 80'd73);
    chk("a_bcd", bus.bcdcount, 80'h01000_99999_00045_00123);
    tick();
    chk("a_busy_low", {79'd0, bus.busy}, 80'd0);
    chk("a_done_pulse", {79'd0, bus.done}, 80'd0);

    // Clamping of 131071, with min and avg invalid
    set_in(17'd131071, 17'd500, 17'd7, 17'd600, 4'b0101);
    pulse_start();
    wait_done(200, lat);
    chk("b_lat", 80'(lat), 80'd73);
    chk("b_bcd", bus.bcdcount, 80'hFFFFF_00007_FFFFF_99999);

    // Invalid max publishes 0, 100000 clamps to 99999, 65536 converts exactly
    set_in(17'd1, 17'd100000, 17'd3, 17'd65536, 4'b1010);
    pulse_start();
    wait_done(200, lat);
    chk("c_bcd", bus.bcdcount, 80'h65536_00000_99999_FFFFF);
    tick();

    // Commit held off for 200 cycles
    bus.commit_enable = 1'b0;
    set_in(17'd0, 17'd9, 17'd10, 17'd54321, 4'hF);
    pulse_start();
    ndone = 0;
    changed = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.done) ndone++;
      if (bus.bcdcount !== 80'h65536_00000_99999_FFFFF) changed = 1'b1;
    end
    chk("d_no_done", 80'(ndone), 80'd0);
    chk("d_unchanged", {79'd0, changed}, 80'd0);
    chk("d_busy", {79'd0, bus.busy}, 80'd1);
    bus.commit_enable = 1'b1;
    tick();
    chk("d_done", {79'd0, bus.done}, 80'd1);
    chk("d_bcd", bus.bcdcount, 80'h54321_00010_00009_00000);
    tick();

    // Starts while busy: the newest one is queued and runs after the first commit
    set_in(17'd77, 17'd1, 17'd2, 17'd3, 4'hF);
    pulse_start();
    ndone = 0;
    done_at[0] = -1; done_at[1] = -1;
    word_at[0] = '0; word_at[1] = '0;
    for (int c = 1; c <= 200; c++) begin
      if (c == 20) bus.lag_current = 17'd5;
      if (c == 40) bus.lag_current = 17'd9;
      bus.start = (c == 20 || c == 40);
      tick();
      bus.start = 1'b0;
      if (bus.done) begin
        if (ndone < 2) begin
          done_at[ndone] = c;
          word_at[ndone] = bus.bcdcount;
        end
        ndone++;
      end
    end
    chk("e_ndone", 80'(ndone), 80'd2);
    chk("e_t1", 80'(done_at[0]), 80'd73);
    chk("e_w1", word_at[0], 80'h00003_00002_00001_00077);
    chk("e_t2", 80'(done_at[1]), 80'd146);
    chk("e_w2", word_at[1], 80'h00003_00002_00001_00009);
    chk("e_idle", {79'd0, bus.busy}, 80'd0);

    // Reset in the middle of a conversion
    set_in(17'd1234, 17'd0, 17'd0, 17'd0, 4'hF);
    pulse_start();
    repeat (29) tick();
    reset = 1'b1;
    tick();
    chk("f_rst_bcd", bus.bcdcount, RST_WORD);
    chk("f_rst_busy", {79'd0, bus.busy}, 80'd0);
    chk("f_rst_done", {79'd0, bus.done}, 80'd0);
    reset = 1'b0;
    tick();
    set_in(17'd42, 17'd0, 17'd0, 17'd0, 4'hF);
    pulse_start();
    wait_done(200, lat);
    chk("f_lat", 80'(lat), 80'd73);
    chk("f_bcd", bus.bcdcount, 80'h00000_00000_00000_00042);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
